// File: rtl/f16_pkg.sv
// rtl/f16_pkg.sv - shared types and constants for the float16 to fixed 8.8 converter
package f16_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        SHIFT,
        ROUND,
        DONE
    } conv_state_t;

    localparam int          F16_BIAS    = 15;
    localparam int          F16_MANT_W  = 10;
    localparam logic [15:0] FIX_POS_SAT = 16'h7FFF;
    localparam logic [15:0] FIX_NEG_SAT = 16'h8000;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] mant;
    } f16_t;

endpackage

// File: rtl/f16_classify.sv
// rtl/f16_classify.sv - unpacks a float16 into class flags, signed shift count and significand
module f16_classify
    import f16_pkg::*;
#(
    parameter int EXP_ORIGIN = 17
) (
    input  logic [15:0]       flt,
    output logic              sign,
    output logic              is_zero,
    output logic              is_special,
    output logic signed [5:0] k,
    output logic [10:0]       sig
);

    f16_t f;

    // Subnormals are below the 8.8 LSB, so they are folded into zero.
    always_comb begin
        f          = f16_t'(flt);
        sign       = f.sign;
        is_zero    = (f.exp == 5'd0);
        is_special = (f.exp == 5'd31);
        k          = $signed({1'b0, f.exp}) - $signed(6'(EXP_ORIGIN));
        sig        = {1'b1, f.mant};
    end

endmodule

// File: rtl/f16_to_fix88_seq.sv
// rtl/f16_to_fix88_seq.sv - multicycle float16 to signed 8.8 converter, 1-bit/cycle shifter, RNE
module f16_to_fix88_seq
    import f16_pkg::*;
#(
    parameter int FRAC    = 8,
    parameter int MAX_RSH = 12,
    parameter int MAX_LSH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] flt_in,
    output logic [15:0] fix_out,
    output logic        ack,
    output logic        busy,
    output logic        sat
);

    localparam int                EXP_ORIGIN = F16_BIAS + F16_MANT_W - FRAC;
    localparam logic signed [5:0] K_MAX      = 6'(MAX_LSH);
    localparam logic signed [5:0] K_FLUSH    = 6'(-MAX_RSH);

    conv_state_t       state;
    f16_t              flt_r;
    logic [15:0]       mag;
    logic              guard;
    logic              sticky;
    logic              left;
    logic [3:0]        cnt;

    logic              c_sign;
    logic              c_zero;
    logic              c_special;
    logic signed [5:0] c_k;
    logic [10:0]       c_sig;
    logic [15:0]       rounded;

    f16_classify #(.EXP_ORIGIN(EXP_ORIGIN)) u_classify (
        .flt        (flt_r),
        .sign       (c_sign),
        .is_zero    (c_zero),
        .is_special (c_special),
        .k          (c_k),
        .sig        (c_sig)
    );

    // Significand is at most 11 bits when right-shifted, so the increment never carries out.
    assign rounded = mag + 16'(guard & (sticky | mag[0]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            flt_r   <= '0;
            mag     <= '0;
            guard   <= 1'b0;
            sticky  <= 1'b0;
            left    <= 1'b0;
            cnt     <= '0;
            fix_out <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            sat     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        flt_r <= f16_t'(flt_in);
                        ack   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    if (c_zero || c_k <= K_FLUSH) begin
                        fix_out <= '0;
                        sat     <= 1'b0;
                        ack     <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else if (c_special || c_k > K_MAX) begin
                        fix_out <= c_sign ? FIX_NEG_SAT : FIX_POS_SAT;
                        sat     <= 1'b1;
                        ack     <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        mag    <= 16'(c_sig);
                        cnt    <= 4'(c_k[5] ? -c_k : c_k);
                        left   <= !c_k[5];
                        guard  <= 1'b0;
                        sticky <= 1'b0;
                        state  <= (c_k != 6'sd0) ? SHIFT : ROUND;
                    end
                end
                SHIFT: begin
                    if (left) begin
                        mag <= mag << 1;
                    end else begin
                        sticky <= sticky | guard;
                        guard  <= mag[0];
                        mag    <= mag >> 1;
                    end
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ROUND;
                end
                ROUND: begin
                    fix_out <= c_sign ? 16'(-rounded) : rounded;
                    sat     <= 1'b0;
                    ack     <= 1'b1;
                    busy    <= 1'b0;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f16_to_fix88_seq.sv
// tb/tb_f16_to_fix88_seq.sv - scoreboard bench for the float16 to fixed 8.8 converter
module tb_f16_to_fix88_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] flt_in = '0;
    logic [15:0] fix_out;
    logic        ack;
    logic        busy;
    logic        sat;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] flt;
        logic [15:0] fix;
        logic        sat;
        int          lat;
    } exp_t;

    exp_t sb[$];

    f16_to_fix88_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .flt_in  (flt_in),
        .fix_out (fix_out),
        .ack     (ack),
        .busy    (busy),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [15:0] f, input logic [15:0] efix, input logic esat, input int elat);
        exp_t e;
        e.flt = f; e.fix = efix; e.sat = esat; e.lat = elat;
        sb.push_back(e);
        flt_in = f;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        flt_in = 16'($urandom);
    endtask

    task automatic wait_ack(output int lat, output logic ok);
        int c;
        lat = 0; ok = 1'b0; c = 0;
        while (!ok && c < 40) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            if (ack) begin
                ok  = 1'b1;
                lat = c;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (fix_out !== 16'h0000) $display("FAIL reset_fix got=%h exp=0000", fix_out); else passed++;
        total++; if (ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (sat !== 1'b0) $display("FAIL reset_sat got=%b exp=0", sat); else passed++;
    endtask

    task automatic test_directed();
        logic [15:0] vf[19]   = '{16'h3C00, 16'h57FF, 16'hD7FF, 16'h5800, 16'hFC00, 16'h1C00, 16'h1800,
                                  16'h1A00, 16'h0000, 16'h8000, 16'h0001, 16'h4C00, 16'h4400, 16'h7E00,
                                  16'h1400, 16'hBC00, 16'h1E00, 16'h9A00, 16'h9800};
        logic [15:0] vfix[19] = '{16'h0100, 16'h7FF0, 16'h8010, 16'h7FFF, 16'h8000, 16'h0001, 16'h0000,
                                  16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0400, 16'h7FFF,
                                  16'h0000, 16'hFF00, 16'h0002, 16'hFFFF, 16'h0000};
        logic        vsat[19] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        int          vlat[19] = '{4, 6, 6, 1, 1, 12, 13, 13, 1, 1, 1, 4, 2, 1, 1, 4, 12, 13, 13};
        int          lat;
        logic        ok;
        exp_t        e;
        for (int i = 0; i < 19; i++) begin
            launch(vf[i], vfix[i], vsat[i], vlat[i]);
            wait_ack(lat, ok);
            e = sb.pop_front();
            total++;
            if (!ok) begin
                $display("FAIL dir_timeout flt=%h no ack within 40 cycles", e.flt);
            end else begin
                passed++;
                total++; if (fix_out !== e.fix) $display("FAIL dir_fix flt=%h got=%h exp=%h", e.flt, fix_out, e.fix); else passed++;
                total++; if (sat !== e.sat) $display("FAIL dir_sat flt=%h got=%b exp=%b", e.flt, sat, e.sat); else passed++;
                total++; if (lat !== e.lat) $display("FAIL dir_lat flt=%h got=%0d exp=%0d", e.flt, lat, e.lat); else passed++;
            end
        end
    endtask

    task automatic test_busy_ignore();
        int          lat;
        logic        ok;
        logic        busy_bad;
        logic        hold_bad;
        logic [15:0] held;
        exp_t        e;
        launch(16'h1C00, 16'h0001, 1'b0, 12);
        lat = 0; ok = 1'b0; busy_bad = 1'b0;
        while (!ok && lat < 40) begin
            start  = (lat >= 1 && lat <= 5);
            flt_in = 16'h3C00;
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ack) ok = 1'b1;
            else if (busy !== 1'b1) busy_bad = 1'b1;
        end
        start = 1'b0;
        e = sb.pop_front();
        total++; if (busy_bad) $display("FAIL busy_high got=0 exp=1 during conversion"); else passed++;
        total++; if (!ok || fix_out !== e.fix) $display("FAIL busy_ignore_fix got=%h exp=%h", fix_out, e.fix); else passed++;
        total++; if (lat !== e.lat) $display("FAIL busy_ignore_lat got=%0d exp=%0d", lat, e.lat); else passed++;
        held = fix_out;
        hold_bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack !== 1'b1 || busy !== 1'b0 || fix_out !== held) hold_bad = 1'b1;
        end
        total++; if (hold_bad) $display("FAIL ack_hold ack=%b fix=%h exp ack=1 fix=%h", ack, fix_out, held); else passed++;
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic ok;
        exp_t e;
        launch(16'h3C00, 16'h0100, 1'b0, 4);
        wait_ack(lat, ok);
        e = sb.pop_front();
        total++; if (!ok || fix_out !== e.fix) $display("FAIL b2b_first got=%h exp=%h", fix_out, e.fix); else passed++;
        launch(16'hFC00, 16'h8000, 1'b1, 1);
        total++; if (ack !== 1'b0) $display("FAIL b2b_ack_drop got=%b exp=0", ack); else passed++;
        wait_ack(lat, ok);
        e = sb.pop_front();
        total++; if (!ok || fix_out !== e.fix || sat !== e.sat || lat !== e.lat)
            $display("FAIL b2b_second got=%h/%b/%0d exp=%h/%b/%0d", fix_out, sat, lat, e.fix, e.sat, e.lat); else passed++;
        launch(16'h57FF, 16'h7FF0, 1'b0, 6);
        wait_ack(lat, ok);
        e = sb.pop_front();
        total++; if (!ok || fix_out !== e.fix || sat !== e.sat || lat !== e.lat)
            $display("FAIL b2b_third got=%h/%b/%0d exp=%h/%b/%0d", fix_out, sat, lat, e.fix, e.sat, e.lat); else passed++;
    endtask

    task automatic test_reset_midop();
        int   lat;
        logic ok;
        exp_t e;
        launch(16'h1C00, 16'h0001, 1'b0, 12);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        total++; if (fix_out !== 16'h0000) $display("FAIL midrst_fix got=%h exp=0000", fix_out); else passed++;
        total++; if (ack !== 1'b0 || busy !== 1'b0 || sat !== 1'b0)
            $display("FAIL midrst_flags got ack=%b busy=%b sat=%b exp 0/0/0", ack, busy, sat); else passed++;
        void'(sb.pop_front());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        launch(16'h1C00, 16'h0001, 1'b0, 12);
        wait_ack(lat, ok);
        e = sb.pop_front();
        total++; if (!ok || fix_out !== e.fix || lat !== e.lat)
            $display("FAIL midrst_after got=%h/%0d exp=%h/%0d", fix_out, lat, e.fix, e.lat); else passed++;
    endtask

    task automatic test_round_trip();
        logic [15:0] mg;
        logic [15:0] x;
        logic [15:0] f;
        logic [9:0]  m;
        int          p;
        int          lat;
        int          bad;
        logic        ok;
        exp_t        e;
        bad = 0;
        for (int t = 0; t < 120; t++) begin
            mg = 16'($urandom_range(1, 32767)) >> $urandom_range(0, 14);
            if (mg == 16'd0) mg = 16'd1;
            p = 0;
            for (int i = 0; i < 16; i++) if (mg[i]) p = i;
            if (p > 10) mg = mg & ~((16'd1 << (p - 10)) - 16'd1);
            m = (p >= 10) ? 10'(mg >> (p - 10)) : 10'(mg << (10 - p));
            x = $urandom_range(0, 1) ? 16'(-mg) : mg;
            f = {x[15], 5'(p + 7), m};
            launch(f, x, 1'b0, (p >= 10) ? 2 + p - 10 : 2 + 10 - p);
            wait_ack(lat, ok);
            e = sb.pop_front();
            total++;
            if (!ok || fix_out !== e.fix || sat !== e.sat || lat !== e.lat) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL round_trip flt=%h got=%h/%b/%0d exp=%h/%b/%0d",
                             e.flt, fix_out, sat, lat, e.fix, e.sat, e.lat);
            end else begin
                passed++;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        test_round_trip();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
